kf8259_interrupt_acknowledge_control: RTL and testbench
=======================================================

Name: kf8259_interrupt_acknowledge_control

Overview:
- Sequencer for the 8259 interrupt request register (IRR). It resolves priority across pending IRR bits, drives INT, and runs the 8086-mode two-pulse INTA sequence.
- During the sequence it holds the IRR frozen, clears the acknowledged IRR bit, and maintains the in-service register (ISR) with rotation and EOI handling.
- Sits between the IRR block and the bus/command decoder.

Parameters:
- IRQ_COUNT, 8, number of request levels; only 8 is supported, present for assertions.
- SPURIOUS_LEVEL, 3'd7, level reported in the vector when no request is valid at the first INTA.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- interrupt_request_register  in  8  IRR contents from the request block.
- interrupt_mask  in  8  IMR; 1 = masked.
- interrupt_acknowledge_n  in  1  INTA#, already synchronised to clock.
- vector_base  in  5  T7..T3 of the interrupt vector.
- auto_eoi  in  1  1 = ISR bit cleared at the end of the second INTA.
- rotate_on_eoi  in  1  1 = the cleared level becomes lowest priority.
- eoi_valid  in  1  one-cycle EOI command strobe.
- eoi_specific  in  1  1 = specific EOI using eoi_level; 0 = non-specific.
- eoi_level  in  3  target level for specific EOI.
- interrupt  out  1  INT to the CPU.
- freeze  out  1  holds the IRR during the acknowledge sequence.
- clear_interrupt_request  out  8  one-cycle clear pulse into the IRR.
- in_service_register  out  8  ISR.
- lowest_priority  out  3  rotation pointer.
- data_out  out  8  vector byte.
- data_out_enable  out  1  bus drive enable for data_out.

Behaviour:
- Reset values: all outputs 0, except lowest_priority = 7 so that IR0 is highest. State = IDLE. Reset acts immediately, including mid-sequence.
- INTA edge detection: the previous INTA# value is registered. A falling edge is prev=1 and now=0; a rising edge is prev=0 and now=1. All outputs are registered and respond one clock after the sampled edge.
- Priority order: level (lowest_priority+1) mod 8 is highest, descending cyclically. All level arithmetic is 3-bit and wraps naturally.
- Winner selection: candidate = IRR & ~IMR. The winner is the highest-priority candidate bit that is strictly higher than the highest-priority ISR bit (fully nested mode).
- interrupt is driven as a registered version of (state==IDLE && winner exists).
- State machine:
  - IDLE: on an INTA falling edge, go to ACK1. Latch level L = winner, or SPURIOUS_LEVEL with a spurious flag if there is no winner. Set freeze=1 and interrupt=0. If not spurious, pulse clear_interrupt_request[L] for one cycle and set ISR[L].
  - ACK1: wait for the INTA rising edge, then go to WAIT2.
  - WAIT2: on an INTA falling edge, go to ACK2. Drive data_out = {vector_base, L} with data_out_enable=1.
  - ACK2: data_out_enable stays 1 while INTA# is low. On the INTA rising edge:
    - data_out_enable=0 and freeze=0; go to IDLE.
    - If auto_eoi and not spurious, clear ISR[L].
    - If auto_eoi, not spurious, and rotate_on_eoi, set lowest_priority = L.
- freeze is 1 in every state except IDLE.
- EOI (accepted in any state):
  - Non-specific EOI clears the highest-priority set ISR bit.
  - Specific EOI clears ISR[eoi_level].
  - If rotate_on_eoi, lowest_priority = the cleared level.
  - EOI with no matching ISR bit: no change to ISR or pointer.
- Simultaneous events:
  - An EOI clear and an acknowledge set in the same cycle are both applied. If they target the same bit, the set wins.
  - An auto-EOI rotation and an EOI rotation in the same cycle: the EOI rotation wins.
- A request removed between INT and the first INTA produces a spurious acknowledge (vector level 7, no ISR change).

Decomposition:
- kf8259_common_pkg holds:
  - the state enum (IDLE, ACK1, WAIT2, ACK2);
  - the IRQ_COUNT constant;
  - functions rotate_right8 and rotate_left8;
  - the function priority_encode8, which returns the lowest set index or 0 with a valid flag.
- One combinational sub-module, kf8259_priority_resolver, with inputs request[7:0] and lowest_priority[2:0], and outputs level[2:0] and valid. It is instantiated once for the winner and once for the highest ISR bit.

Test Plan:
- Basic acknowledge: IRR=8'h04, IMR=0, vector_base=5'h08 → interrupt=1. First INTA → clear_interrupt_request=8'h04 (1 cycle), ISR=8'h04, freeze=1. Second INTA → data_out=8'h42, data_out_enable=1.
- Priority, EOI and rotation: IRR=8'h81 → L=0, ISR=8'h01. Then non-specific EOI with rotate_on_eoi=1 → ISR=0, lowest_priority=0. Next acknowledge with IRR still 8'h80 → L=7.
- Nesting: ISR=8'h02 with IRR=8'h08 → interrupt=0. IRR=8'h01 → interrupt=1.
- Spurious acknowledge: IRR drops to 0 before the first INTA → data_out={vector_base,3'd7}, ISR unchanged, clear_interrupt_request=0.
- Auto-EOI and masking: auto_eoi=1, IRR=8'h10 → ISR[4] set at the first INTA and cleared one cycle after the second INTA rises. IMR=8'h10 with IRR=8'h10 → interrupt never asserts.
- Reset mid-sequence: assert reset_n=0 in WAIT2 → freeze=0, ISR=0, data_out_enable=0, lowest_priority=7 immediately (asynchronously).

Source files
------------

// File: rtl/kf8259_interrupt_acknowledge_control_pkg.sv
// Shared types and helpers for the 8259 acknowledge sequencer: sequence states,
// byte rotation and a lowest-index priority encoder.
package kf8259_common_pkg;

   localparam int IRQ_COUNT = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACK1  = 2'd1,
      WAIT2 = 2'd2,
      ACK2  = 2'd3
   } ack_state_t;

   typedef struct packed {
      logic       valid;
      logic [2:0] index;
   } prio_result_t;

   function automatic logic [7:0] rotate_right8(input logic [7:0] value, input logic [2:0] amount);
      logic [15:0] doubled;
      doubled = {value, value};
      return doubled[amount +: 8];
   endfunction

   function automatic logic [7:0] rotate_left8(input logic [7:0] value, input logic [2:0] amount);
      logic [15:0] doubled;
      logic [3:0]  start;
      doubled = {value, value};
      start   = 4'd8 - {1'b0, amount};
      return doubled[start +: 8];
   endfunction

   function automatic prio_result_t priority_encode8(input logic [7:0] value);
      prio_result_t result;
      result.valid = |value;
      result.index = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (value[i]) result.index = 3'(i);
      end
      return result;
   endfunction

endpackage

// File: rtl/kf8259_interrupt_acknowledge_control_if.sv
// Request/bus/command signal bundle around the acknowledge sequencer.
interface kf8259_interrupt_acknowledge_control_if;

   logic [7:0] interrupt_request_register;
   logic [7:0] interrupt_mask;
   logic       interrupt_acknowledge_n;
   logic [4:0] vector_base;
   logic       auto_eoi;
   logic       rotate_on_eoi;
   logic       eoi_valid;
   logic       eoi_specific;
   logic [2:0] eoi_level;
   logic       interrupt;
   logic       freeze;
   logic [7:0] clear_interrupt_request;
   logic [7:0] in_service_register;
   logic [2:0] lowest_priority;
   logic [7:0] data_out;
   logic       data_out_enable;

   modport slave (
      input  interrupt_request_register,
      input  interrupt_mask,
      input  interrupt_acknowledge_n,
      input  vector_base,
      input  auto_eoi,
      input  rotate_on_eoi,
      input  eoi_valid,
      input  eoi_specific,
      input  eoi_level,
      output interrupt,
      output freeze,
      output clear_interrupt_request,
      output in_service_register,
      output lowest_priority,
      output data_out,
      output data_out_enable
   );

   modport master (
      output interrupt_request_register,
      output interrupt_mask,
      output interrupt_acknowledge_n,
      output vector_base,
      output auto_eoi,
      output rotate_on_eoi,
      output eoi_valid,
      output eoi_specific,
      output eoi_level,
      input  interrupt,
      input  freeze,
      input  clear_interrupt_request,
      input  in_service_register,
      input  lowest_priority,
      input  data_out,
      input  data_out_enable
   );

endinterface

// File: rtl/kf8259_interrupt_acknowledge_control_priority_resolver.sv
// Picks the highest-priority set bit of a request byte under a rotating
// pointer: level (lowest_priority+1) is highest, descending cyclically.
module kf8259_priority_resolver
   import kf8259_common_pkg::*;
(
   input  logic [7:0] request,
   input  logic [2:0] lowest_priority,
   output logic [2:0] level,
   output logic       valid
);

   logic [2:0]   highest;
   prio_result_t encoded;

   assign highest = lowest_priority + 3'd1;

   // Rotate so the highest-priority level lands on bit 0, then undo the offset.
   always_comb begin
      encoded = priority_encode8(rotate_right8(request, highest));
   end

   assign level = encoded.index + highest;
   assign valid = encoded.valid;

endmodule

// File: rtl/kf8259_interrupt_acknowledge_control.sv
// 8259 interrupt acknowledge sequencer: priority resolution, INT generation,
// 8086 two-pulse INTA handling and ISR / rotation / EOI maintenance.
//
//   state | meaning
//   IDLE  | no acknowledge in progress; INT follows the resolved winner
//   ACK1  | first INTA# low seen, level latched; waiting for INTA# to rise
//   WAIT2 | between pulses; waiting for second INTA# falling edge
//   ACK2  | vector on the bus while INTA# low; release on rising edge
module kf8259_interrupt_acknowledge_control #(
   parameter int         IRQ_COUNT      = kf8259_common_pkg::IRQ_COUNT,
   parameter logic [2:0] SPURIOUS_LEVEL = 3'd7
) (
   input logic                                  clock,
   input logic                                  reset_n,
   kf8259_interrupt_acknowledge_control_if.slave bus
);

   import kf8259_common_pkg::*;

   if (IRQ_COUNT != 8) begin : g_irq_count_check
      $error("kf8259_interrupt_acknowledge_control supports only IRQ_COUNT = 8");
   end

   ack_state_t state;
   logic       inta_prev;
   logic [2:0] ack_level;
   logic       ack_spurious;

   logic       inta_fall;
   logic       inta_rise;
   logic [7:0] candidate;
   logic [2:0] req_level;
   logic       req_valid;
   logic [2:0] isr_level;
   logic       isr_valid;
   logic [2:0] highest;
   logic [2:0] req_rank;
   logic [2:0] isr_rank;
   logic       winner_valid;

   logic       ack_take;
   logic       auto_clear;
   logic       eoi_hit;
   logic [2:0] eoi_target;
   logic [7:0] isr_set;
   logic [7:0] isr_clear;
   logic [7:0] isr_next;
   logic [2:0] lowest_next;

   assign inta_fall = inta_prev & ~bus.interrupt_acknowledge_n;
   assign inta_rise = ~inta_prev & bus.interrupt_acknowledge_n;
   assign candidate = bus.interrupt_request_register & ~bus.interrupt_mask;

   kf8259_priority_resolver u_request_resolver (
      .request         (candidate),
      .lowest_priority (bus.lowest_priority),
      .level           (req_level),
      .valid           (req_valid)
   );

   kf8259_priority_resolver u_service_resolver (
      .request         (bus.in_service_register),
      .lowest_priority (bus.lowest_priority),
      .level           (isr_level),
      .valid           (isr_valid)
   );

   // Rank 0 is the highest priority; fully nested means strictly better rank.
   assign highest      = bus.lowest_priority + 3'd1;
   assign req_rank     = req_level - highest;
   assign isr_rank     = isr_level - highest;
   assign winner_valid = req_valid && (!isr_valid || (req_rank < isr_rank));

   always_comb begin
      ack_take    = (state == IDLE) && inta_fall;
      auto_clear  = (state == ACK2) && inta_rise && bus.auto_eoi && !ack_spurious;
      eoi_target  = bus.eoi_specific ? bus.eoi_level : isr_level;
      eoi_hit     = bus.eoi_valid &&
                    (bus.eoi_specific ? bus.in_service_register[bus.eoi_level] : isr_valid);
      isr_set     = 8'h00;
      isr_clear   = 8'h00;
      lowest_next = bus.lowest_priority;
      if (ack_take && winner_valid) isr_set = rotate_left8(8'h01, req_level);
      if (eoi_hit) isr_clear = isr_clear | rotate_left8(8'h01, eoi_target);
      if (auto_clear) isr_clear = isr_clear | rotate_left8(8'h01, ack_level);
      // A set in the same cycle as a clear of the same bit must survive.
      isr_next = (bus.in_service_register & ~isr_clear) | isr_set;
      if (eoi_hit && bus.rotate_on_eoi) begin
         lowest_next = eoi_target;
      end else if (auto_clear && bus.rotate_on_eoi) begin
         lowest_next = ack_level;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state                       <= IDLE;
         inta_prev                   <= 1'b1;
         ack_level                   <= 3'd0;
         ack_spurious                <= 1'b0;
         bus.interrupt               <= 1'b0;
         bus.freeze                  <= 1'b0;
         bus.clear_interrupt_request <= 8'h00;
         bus.in_service_register     <= 8'h00;
         bus.lowest_priority         <= 3'd7;
         bus.data_out                <= 8'h00;
         bus.data_out_enable         <= 1'b0;
      end else begin
         inta_prev                   <= bus.interrupt_acknowledge_n;
         bus.clear_interrupt_request <= 8'h00;
         bus.in_service_register     <= isr_next;
         bus.lowest_priority         <= lowest_next;
         bus.interrupt               <= (state == IDLE) && winner_valid && !inta_fall;
         case (state)
            IDLE: begin
               if (inta_fall) begin
                  state      <= ACK1;
                  bus.freeze <= 1'b1;
                  if (winner_valid) begin
                     ack_level                   <= req_level;
                     ack_spurious                <= 1'b0;
                     bus.clear_interrupt_request <= rotate_left8(8'h01, req_level);
                  end else begin
                     ack_level    <= SPURIOUS_LEVEL;
                     ack_spurious <= 1'b1;
                  end
               end
            end
            ACK1: begin
               if (inta_rise) state <= WAIT2;
            end
            WAIT2: begin
               if (inta_fall) begin
                  state               <= ACK2;
                  bus.data_out        <= {bus.vector_base, ack_level};
                  bus.data_out_enable <= 1'b1;
               end
            end
            ACK2: begin
               if (inta_rise) begin
                  state               <= IDLE;
                  bus.freeze          <= 1'b0;
                  bus.data_out_enable <= 1'b0;
               end
            end
            default: begin
               state               <= IDLE;
               bus.freeze          <= 1'b0;
               bus.data_out_enable <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_kf8259_interrupt_acknowledge_control.sv
// Directed bench for the 8259 acknowledge sequencer; clear pulses and vector
// bytes are scoreboarded, state observations are checked inline.
module tb_kf8259_interrupt_acknowledge_control;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;

   int vectors     = 0;
   int miscompares = 0;

   logic [7:0] clear_q[$];
   logic [7:0] vec_q[$];

   kf8259_interrupt_acknowledge_control_if bus ();

   kf8259_interrupt_acknowledge_control dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [7:0] actual, input logic [7:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   // Scoreboard monitor: pops whenever a clear pulse or a new vector appears.
   initial begin : monitor
      logic       doe_prev;
      logic [7:0] expected;
      doe_prev = 1'b0;
      forever begin
         @(negedge clock);
         if (reset_n) begin
            if (bus.clear_interrupt_request != 8'h00) begin
               if (clear_q.size() == 0) begin
                  check("clear_unexpected", bus.clear_interrupt_request, 8'h00);
               end else begin
                  expected = clear_q.pop_front();
                  check("clear_pulse", bus.clear_interrupt_request, expected);
               end
            end
            if (bus.data_out_enable && !doe_prev) begin
               if (vec_q.size() == 0) begin
                  check("vector_unexpected", bus.data_out, 8'hxx);
               end else begin
                  expected = vec_q.pop_front();
                  check("vector", bus.data_out, expected);
               end
            end
         end
         doe_prev = bus.data_out_enable;
      end
   end

   task automatic do_ack(input logic [7:0] exp_clear, input logic [7:0] exp_vec,
                         input logic [7:0] isr_mid, input logic [7:0] isr_end,
                         input logic [7:0] irr_after);
      if (exp_clear != 8'h00) clear_q.push_back(exp_clear);
      vec_q.push_back(exp_vec);
      bus.interrupt_acknowledge_n = 1'b0;
      tick(1);
      check("ack1_freeze", 8'(bus.freeze), 8'h01);
      check("ack1_isr", bus.in_service_register, isr_mid);
      check("ack1_int", 8'(bus.interrupt), 8'h00);
      bus.interrupt_request_register = irr_after;
      bus.interrupt_acknowledge_n = 1'b1;
      tick(1);
      check("wait2_freeze", 8'(bus.freeze), 8'h01);
      bus.interrupt_acknowledge_n = 1'b0;
      tick(1);
      check("ack2_doe", 8'(bus.data_out_enable), 8'h01);
      check("ack2_isr", bus.in_service_register, isr_mid);
      tick(1);
      check("ack2_doe_hold", 8'(bus.data_out_enable), 8'h01);
      bus.interrupt_acknowledge_n = 1'b1;
      tick(1);
      check("end_doe", 8'(bus.data_out_enable), 8'h00);
      check("end_freeze", 8'(bus.freeze), 8'h00);
      check("end_isr", bus.in_service_register, isr_end);
   endtask

   task automatic eoi(input logic specific, input logic [2:0] level);
      bus.eoi_valid    = 1'b1;
      bus.eoi_specific = specific;
      bus.eoi_level    = level;
      tick(1);
      bus.eoi_valid    = 1'b0;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stimulus
      bus.interrupt_request_register = 8'h00;
      bus.interrupt_mask             = 8'h00;
      bus.interrupt_acknowledge_n    = 1'b1;
      bus.vector_base                = 5'h08;
      bus.auto_eoi                   = 1'b0;
      bus.rotate_on_eoi              = 1'b0;
      bus.eoi_valid                  = 1'b0;
      bus.eoi_specific               = 1'b0;
      bus.eoi_level                  = 3'd0;
      tick(2);
      check("rst_int", 8'(bus.interrupt), 8'h00);
      check("rst_freeze", 8'(bus.freeze), 8'h00);
      check("rst_isr", bus.in_service_register, 8'h00);
      check("rst_lp", 8'(bus.lowest_priority), 8'h07);
      check("rst_doe", 8'(bus.data_out_enable), 8'h00);
      check("rst_dout", bus.data_out, 8'h00);

      // Basic acknowledge of IR2
      reset_n = 1'b1;
      bus.interrupt_request_register = 8'h04;
      tick(1);
      check("basic_int", 8'(bus.interrupt), 8'h01);
      do_ack(8'h04, 8'h42, 8'h04, 8'h04, 8'h00);
      eoi(1'b0, 3'd0);
      check("basic_eoi_isr", bus.in_service_register, 8'h00);
      check("basic_eoi_lp", 8'(bus.lowest_priority), 8'h07);

      // Priority, non-specific EOI with rotation
      bus.interrupt_request_register = 8'h81;
      tick(1);
      check("prio_int", 8'(bus.interrupt), 8'h01);
      do_ack(8'h01, 8'h40, 8'h01, 8'h01, 8'h80);
      tick(1);
      check("prio_nested_int", 8'(bus.interrupt), 8'h00);
      bus.rotate_on_eoi = 1'b1;
      eoi(1'b0, 3'd0);
      check("rot_isr", bus.in_service_register, 8'h00);
      check("rot_lp", 8'(bus.lowest_priority), 8'h00);
      tick(1);
      check("rot_int", 8'(bus.interrupt), 8'h01);
      do_ack(8'h80, 8'h47, 8'h80, 8'h80, 8'h00);
      eoi(1'b1, 3'd7);
      check("spec_eoi_isr", bus.in_service_register, 8'h00);
      check("spec_eoi_lp", 8'(bus.lowest_priority), 8'h07);
      bus.rotate_on_eoi = 1'b0;

      // Nesting: IR3 blocked by IR1 in service, IR0 gets through
      bus.interrupt_request_register = 8'h02;
      tick(1);
      do_ack(8'h02, 8'h41, 8'h02, 8'h02, 8'h00);
      bus.interrupt_request_register = 8'h08;
      tick(1);
      check("nest_lower_int", 8'(bus.interrupt), 8'h00);
      bus.interrupt_request_register = 8'h01;
      tick(1);
      check("nest_higher_int", 8'(bus.interrupt), 8'h01);
      bus.interrupt_request_register = 8'h00;
      eoi(1'b0, 3'd0);
      check("nest_eoi_isr", bus.in_service_register, 8'h00);

      // Spurious: request withdrawn before first INTA
      bus.interrupt_request_register = 8'h20;
      tick(1);
      check("spur_int", 8'(bus.interrupt), 8'h01);
      bus.interrupt_request_register = 8'h00;
      tick(1);
      check("spur_int_drop", 8'(bus.interrupt), 8'h00);
      do_ack(8'h00, 8'h47, 8'h00, 8'h00, 8'h00);

      // Auto-EOI with rotation
      bus.auto_eoi      = 1'b1;
      bus.rotate_on_eoi = 1'b1;
      bus.interrupt_request_register = 8'h10;
      tick(1);
      check("aeoi_int", 8'(bus.interrupt), 8'h01);
      do_ack(8'h10, 8'h44, 8'h10, 8'h00, 8'h00);
      check("aeoi_lp", 8'(bus.lowest_priority), 8'h04);
      bus.auto_eoi      = 1'b0;
      bus.rotate_on_eoi = 1'b0;

      // Masked request never raises INT
      bus.interrupt_mask             = 8'h10;
      bus.interrupt_request_register = 8'h10;
      for (int i = 0; i < 6; i++) begin
         tick(1);
         check("mask_int", 8'(bus.interrupt), 8'h00);
      end
      bus.interrupt_mask             = 8'h00;
      bus.interrupt_request_register = 8'h00;
      tick(1);

      // Asynchronous reset while waiting for the second INTA
      bus.interrupt_request_register = 8'h01;
      tick(1);
      check("rstseq_int", 8'(bus.interrupt), 8'h01);
      clear_q.push_back(8'h01);
      bus.interrupt_acknowledge_n = 1'b0;
      tick(1);
      check("rstseq_isr", bus.in_service_register, 8'h01);
      bus.interrupt_request_register = 8'h00;
      bus.interrupt_acknowledge_n = 1'b1;
      tick(1);
      check("rstseq_freeze", 8'(bus.freeze), 8'h01);
      #2 reset_n = 1'b0;
      #1;
      check("async_freeze", 8'(bus.freeze), 8'h00);
      check("async_isr", bus.in_service_register, 8'h00);
      check("async_doe", 8'(bus.data_out_enable), 8'h00);
      check("async_lp", 8'(bus.lowest_priority), 8'h07);
      tick(1);
      reset_n = 1'b1;
      tick(2);
      check("post_rst_int", 8'(bus.interrupt), 8'h00);

      check("clear_q_drained", 8'(clear_q.size()), 8'h00);
      check("vec_q_drained", 8'(vec_q.size()), 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
